rf_sequencer: RTL

Multi-cycle instruction sequencer driving the two-entry, 4-bit register file and its write-data path. It fetches 10-bit instruction words from an external asynchronous-read ROM, decodes them, and drives the register-file select, destination, write-enable, write-data-source and ALU-operation controls one instruction at a time. It sits at the top of the whole-system datapath, between the program ROM and the register file/ALU pair.

---
 rtl/rf_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rf_sequencer.sv
// Multi-cycle instruction sequencer for the two-entry 4-bit register file.
// Fetches 10-bit words from an async-read ROM and drives RF/ALU controls.
module rf_sequencer (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] rom_data,
   output logic [3:0] rom_addr,
   output logic       SA,
   output logic       SB,
   output logic       DA,
   output logic       W,
   output logic       d_sel,
   output logic [3:0] imm,
   output logic [1:0] alu_op,
   output logic       busy,
   output logic       halted,
   output logic [7:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALTED
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   state_t     r_state, w_state_next;
   logic [3:0] r_pc, w_pc_next;
   logic [9:0] r_ir, w_ir_next;
   logic [7:0] r_count, w_count_next;

   logic [2:0] w_op;
   logic [2:0] w_op_minus2;
   logic       w_is_alu;
   logic [7:0] w_count_inc;

   assign w_op        = r_ir[9:7];
   assign w_op_minus2 = w_op - 3'd2;
   assign w_is_alu    = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                        (w_op == OP_AND) || (w_op == OP_OR);
   // Retired-instruction counter sticks at 255 instead of wrapping.
   assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= 4'd0;
         r_ir    <= 10'd0;
         r_count <= 8'd0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_ir    <= w_ir_next;
         r_count <= w_count_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_ir_next    = r_ir;
      w_count_next = r_count;
      case (r_state)
         S_IDLE: begin
            w_pc_next = 4'd0;
            if (start) begin
               w_state_next = S_FETCH;
               w_count_next = 8'd0;
            end
         end
         S_FETCH: begin
            w_ir_next    = rom_data;
            w_pc_next    = r_pc + 4'd1;
            w_state_next = S_DECODE;
         end
         S_DECODE: begin
            case (w_op)
               OP_NOP: begin
                  w_state_next = S_FETCH;
                  w_count_next = w_count_inc;
               end
               OP_JMP: begin
                  w_pc_next    = r_ir[3:0];
                  w_state_next = S_FETCH;
                  w_count_next = w_count_inc;
               end
               OP_HALT: begin
                  w_state_next = S_HALTED;
               end
               default: begin
                  w_state_next = S_EXEC;
                  w_count_next = w_count_inc;
               end
            endcase
         end
         S_EXEC: begin
            w_state_next = S_FETCH;
         end
         S_HALTED: begin
            if (start) begin
               w_pc_next    = 4'd0;
               w_count_next = 8'd0;
               w_state_next = S_FETCH;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign rom_addr    = r_pc;
   assign DA          = r_ir[6];
   assign SA          = r_ir[5];
   assign SB          = r_ir[4];
   assign imm         = r_ir[3:0];
   assign W           = (r_state == S_EXEC);
   assign d_sel       = w_is_alu;
   assign alu_op      = w_is_alu ? w_op_minus2[1:0] : 2'b00;
   assign busy        = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
   assign halted      = (r_state == S_HALTED);
   assign instr_count = r_count;

   // LDI is the only non-ALU opcode that reaches EXEC; keeps the encoding self-documenting.
   logic w_unused_ldi;
   assign w_unused_ldi = (w_op == OP_LDI);

endmodule
